// File: rtl/cnn_line_pkg.sv
// Shared types, widths and bank-rotation helper for the line-window read path.
package cnn_line_pkg;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned PIX_W  = 24;
   localparam int unsigned CNT_W  = 12;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StDrain
   } lwr_state_t;

   // Banks rotate mod 4, so only the low two bits of the row count matter.
   function automatic logic [1:0] bank_sel(input logic [1:0] n, input logic [1:0] offset);
      return n + offset;
   endfunction

endpackage

// File: rtl/window_shift_3x3.sv
// 3x3 pixel shift window: new column enters at c=2, column counter drives win_valid.
module window_shift_3x3
   import cnn_line_pkg::*;
#(
   parameter int unsigned IMG_W = 28
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_flush,
   input  logic                 i_beat,
   input  logic [PIX_W-1:0]     i_top,
   input  logic [PIX_W-1:0]     i_mid,
   input  logic [PIX_W-1:0]     i_bot,
   output logic [9*PIX_W-1:0]   o_win,
   output logic                 o_win_valid,
   output logic                 o_row_end
);

   logic [9*PIX_W-1:0] r_win;
   logic [9*PIX_W-1:0] w_win_d;
   logic [ADDR_W-1:0]  r_col;
   logic [ADDR_W-1:0]  w_col_d;
   logic               r_valid;
   logic               w_valid_d;
   logic [3*PIX_W-1:0] w_col_in;

   assign w_col_in = {i_bot, i_mid, i_top};

   always_comb begin
      w_win_d   = r_win;
      w_col_d   = r_col;
      w_valid_d = 1'b0;
      if (i_flush) begin
         w_col_d = '0;
      end else if (i_beat) begin
         for (int r = 0; r < 3; r++) begin
            w_win_d[PIX_W*(3*r)   +: PIX_W] = r_win[PIX_W*(3*r+1) +: PIX_W];
            w_win_d[PIX_W*(3*r+1) +: PIX_W] = r_win[PIX_W*(3*r+2) +: PIX_W];
            w_win_d[PIX_W*(3*r+2) +: PIX_W] = w_col_in[PIX_W*r +: PIX_W];
         end
         // A full row always delivers IMG_W beats, so the count restarts on the next row.
         w_col_d   = (r_col == ADDR_W'(IMG_W)) ? ADDR_W'(1) : r_col + ADDR_W'(1);
         w_valid_d = (w_col_d >= ADDR_W'(3));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win   <= '0;
         r_col   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_win   <= w_win_d;
         r_col   <= w_col_d;
         r_valid <= w_valid_d;
      end
   end

   assign o_win       = r_win;
   assign o_win_valid = r_valid;
   assign o_row_end   = r_valid && (r_col == ADDR_W'(IMG_W));

endmodule

// File: rtl/line_window_reader.sv
// Read controller for the 4-bank rotating row buffer; reads three stored rows in
// lockstep and feeds a 3x3 sliding window.
module line_window_reader
   import cnn_line_pkg::*;
#(
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 RESET,
   input  logic                 frame_start,
   input  logic                 row_done,
   input  logic [PIX_W-1:0]     in0_q,
   input  logic [PIX_W-1:0]     in1_q,
   input  logic [PIX_W-1:0]     in2_q,
   input  logic [PIX_W-1:0]     in3_q,
   output logic [ADDR_W-1:0]    rd_addr,
   output logic                 in0_rden,
   output logic                 in1_rden,
   output logic                 in2_rden,
   output logic                 in3_rden,
   output logic [9*PIX_W-1:0]   win,
   output logic                 win_valid,
   output logic                 win_last,
   output logic                 overrun
);

   lwr_state_t        r_state, w_state_d;
   logic [CNT_W-1:0]  r_row_cnt, w_row_cnt_d, w_row_inc;
   logic [1:0]        r_sel_top, r_sel_mid, r_sel_bot;
   logic [1:0]        w_sel_top_d, w_sel_mid_d, w_sel_bot_d;
   logic [ADDR_W-1:0] r_addr, w_addr_d;
   logic [7:0]        r_drain, w_drain_d;
   logic              r_overrun, w_overrun_d;
   logic              r_last_row, w_last_row_d;
   logic [RD_LAT-1:0] r_vld_pipe;
   logic              w_issue;
   logic              w_beat;
   logic              w_row_end;
   logic [3:0]        w_rden;
   logic [PIX_W-1:0]  w_q [4];

   assign w_row_inc = (r_row_cnt == CNT_W'(IMG_H)) ? '0 : r_row_cnt + CNT_W'(1);

   always_comb begin
      w_state_d    = r_state;
      w_row_cnt_d  = r_row_cnt;
      w_sel_top_d  = r_sel_top;
      w_sel_mid_d  = r_sel_mid;
      w_sel_bot_d  = r_sel_bot;
      w_addr_d     = r_addr;
      w_drain_d    = r_drain;
      w_overrun_d  = r_overrun;
      w_last_row_d = r_last_row;
      if (frame_start) begin
         w_state_d    = StIdle;
         w_row_cnt_d  = '0;
         w_addr_d     = '0;
         w_last_row_d = 1'b0;
      end else begin
         if (row_done) begin
            w_row_cnt_d = w_row_inc;
            if (r_state != StIdle) w_overrun_d = 1'b1;
         end
         unique case (r_state)
            StIdle: begin
               if (row_done && (w_row_inc >= CNT_W'(3))) begin
                  w_state_d    = StRead;
                  w_addr_d     = '0;
                  w_sel_top_d  = bank_sel(w_row_inc[1:0], 2'd0);
                  w_sel_mid_d  = bank_sel(w_row_inc[1:0], 2'd1);
                  w_sel_bot_d  = bank_sel(w_row_inc[1:0], 2'd2);
                  w_last_row_d = (w_row_inc == CNT_W'(IMG_H));
               end
            end
            StRead: begin
               if (r_addr == ADDR_W'(IMG_W - 1)) begin
                  w_state_d = StDrain;
                  w_drain_d = '0;
               end else begin
                  w_addr_d = r_addr + ADDR_W'(1);
               end
            end
            StDrain: begin
               if (r_drain == 8'(RD_LAT - 1)) w_state_d = StIdle;
               else                           w_drain_d = r_drain + 8'd1;
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_state    <= StIdle;
         r_row_cnt  <= '0;
         r_sel_top  <= '0;
         r_sel_mid  <= '0;
         r_sel_bot  <= '0;
         r_addr     <= '0;
         r_drain    <= '0;
         r_overrun  <= 1'b0;
         r_last_row <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_row_cnt  <= w_row_cnt_d;
         r_sel_top  <= w_sel_top_d;
         r_sel_mid  <= w_sel_mid_d;
         r_sel_bot  <= w_sel_bot_d;
         r_addr     <= w_addr_d;
         r_drain    <= w_drain_d;
         r_overrun  <= w_overrun_d;
         r_last_row <= w_last_row_d;
      end
   end

   assign w_issue = (r_state == StRead);

   // Delays the issue strobe by RD_LAT so it lines up with bank q.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET)           r_vld_pipe <= '0;
      else if (frame_start) r_vld_pipe <= '0;
      else                  r_vld_pipe <= RD_LAT'({r_vld_pipe, w_issue});
   end

   assign w_beat = r_vld_pipe[RD_LAT-1];

   always_comb begin
      w_rden = '0;
      if (w_issue) begin
         w_rden[r_sel_top] = 1'b1;
         w_rden[r_sel_mid] = 1'b1;
         w_rden[r_sel_bot] = 1'b1;
      end
      w_q[0] = in0_q;
      w_q[1] = in1_q;
      w_q[2] = in2_q;
      w_q[3] = in3_q;
   end

   window_shift_3x3 #(
      .IMG_W (IMG_W)
   ) u_window (
      .clk         (clk),
      .rst_n       (RESET),
      .i_flush     (frame_start),
      .i_beat      (w_beat),
      .i_top       (w_q[r_sel_top]),
      .i_mid       (w_q[r_sel_mid]),
      .i_bot       (w_q[r_sel_bot]),
      .o_win       (win),
      .o_win_valid (win_valid),
      .o_row_end   (w_row_end)
   );

   assign rd_addr  = r_addr;
   assign in0_rden = w_rden[0];
   assign in1_rden = w_rden[1];
   assign in2_rden = w_rden[2];
   assign in3_rden = w_rden[3];
   assign win_last = w_row_end && r_last_row;
   assign overrun  = r_overrun;

endmodule
